// File: rtl/fifo_dir_pkg.sv
// Shared types and constants for the bidirectional FIFO direction controller.
package fifo_dir_pkg;

  typedef enum logic [1:0] {
    ST_AB   = 2'd0,
    ST_BA   = 2'd1,
    ST_TURN = 2'd2
  } state_e;

  localparam logic DIR_AB = 1'b0;
  localparam logic DIR_BA = 1'b1;

  function automatic int unsigned cnt_w(input int unsigned addrsize);
    return addrsize + 1;
  endfunction

endpackage

// File: rtl/fifo_dir_ctrl_if.sv
// Handshake and memory-port signals for both requester sides of fifo_dir_ctrl.
interface fifo_dir_ctrl_if #(
  parameter int unsigned ADDRSIZE = 4
);
  logic                a_push_req;
  logic                a_push_ack;
  logic                a_rvalid;
  logic                a_pop;
  logic                a_rinc;
  logic [ADDRSIZE-1:0] a_addr;
  logic                b_push_req;
  logic                b_push_ack;
  logic                b_rvalid;
  logic                b_pop;
  logic                b_rinc;
  logic [ADDRSIZE-1:0] b_addr;

  modport master (
    output a_push_req, a_pop, b_push_req, b_pop,
    input  a_push_ack, a_rvalid, a_rinc, a_addr,
    input  b_push_ack, b_rvalid, b_rinc, b_addr
  );

  modport slave (
    input  a_push_req, a_pop, b_push_req, b_pop,
    output a_push_ack, a_rvalid, a_rinc, a_addr,
    output b_push_ack, b_rvalid, b_rinc, b_addr
  );
endinterface

// File: rtl/fifo_dir_ptr.sv
// Write/read pointers and fill count for the shared FIFO memory.
module fifo_dir_ptr
  import fifo_dir_pkg::*;
#(
  parameter int unsigned ADDRSIZE = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         inc,
  input  logic                         dec,
  input  logic                         clr,
  output logic [ADDRSIZE-1:0]          wptr,
  output logic [ADDRSIZE-1:0]          rptr,
  output logic [cnt_w(ADDRSIZE)-1:0]   count,
  output logic                         full,
  output logic                         empty
);
  localparam int unsigned CW = cnt_w(ADDRSIZE);
  localparam logic [CW-1:0] DEPTH = {1'b1, {ADDRSIZE{1'b0}}};

  logic [ADDRSIZE-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]       count_q, count_d;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (clr) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (inc) wptr_d = wptr_q + ADDRSIZE'(1);
      if (dec) rptr_d = rptr_q + ADDRSIZE'(1);
      case ({inc, dec})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  assign wptr  = wptr_q;
  assign rptr  = rptr_q;
  assign count = count_q;
  assign full  = (count_q == DEPTH);
  assign empty = (count_q == '0);
endmodule

// File: rtl/fifo_dir_ctrl.sv
// Direction FSM, burst fairness and port muxing for a bidirectional FIFO memory.
module fifo_dir_ctrl
  import fifo_dir_pkg::*;
#(
  parameter int unsigned ADDRSIZE  = 4,
  parameter int unsigned BURST_MAX = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  fifo_dir_ctrl_if.slave             bus,
  output logic                       dir,
  output logic [cnt_w(ADDRSIZE)-1:0] count
);
  localparam logic [7:0] BURST_LIM = 8'(BURST_MAX);

  state_e              state_q, state_d;
  logic                dir_q, dir_d;
  logic [7:0]          burst_q, burst_d;
  logic                inc, dec, clr, full, empty;
  logic [ADDRSIZE-1:0] wptr, rptr;
  logic                snd_is_b, snd_req, oth_req, rcv_pop, at_limit;
  logic                push_acc, pop_acc;

  fifo_dir_ptr #(.ADDRSIZE(ADDRSIZE)) u_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (inc),
    .dec   (dec),
    .clr   (clr),
    .wptr  (wptr),
    .rptr  (rptr),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    burst_d  = burst_q;
    push_acc = 1'b0;
    pop_acc  = 1'b0;
    clr      = 1'b0;
    snd_is_b = (state_q == ST_BA);
    snd_req  = snd_is_b ? bus.b_push_req : bus.a_push_req;
    oth_req  = snd_is_b ? bus.a_push_req : bus.b_push_req;
    rcv_pop  = snd_is_b ? bus.a_pop      : bus.b_pop;
    at_limit = (burst_q == BURST_LIM);
    if (state_q == ST_TURN) begin
      clr     = 1'b1;
      dir_d   = (dir_q == DIR_AB) ? DIR_BA : DIR_AB;
      state_d = (dir_q == DIR_AB) ? ST_BA : ST_AB;
    end else begin
      // An exhausted burst with the other side waiting holds off the sender
      // so the buffer can drain to empty and the switch can happen.
      push_acc = snd_req & ~full & ~(at_limit & oth_req);
      pop_acc  = rcv_pop & ~empty;
      if (empty & ~push_acc & oth_req & (~snd_req | at_limit)) begin
        state_d = ST_TURN;
        burst_d = '0;
      end else if (push_acc & ~at_limit) begin
        burst_d = burst_q + 8'd1;
      end
    end
    inc = push_acc;
    dec = pop_acc;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_AB;
      dir_q   <= DIR_AB;
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      burst_q <= burst_d;
    end
  end

  always_comb begin
    bus.a_push_ack = 1'b0;
    bus.b_push_ack = 1'b0;
    bus.a_rvalid   = 1'b0;
    bus.b_rvalid   = 1'b0;
    bus.a_rinc     = 1'b0;
    bus.b_rinc     = 1'b0;
    bus.a_addr     = '0;
    bus.b_addr     = '0;
    case (state_q)
      ST_AB: begin
        bus.a_push_ack = push_acc;
        bus.a_addr     = wptr;
        bus.b_addr     = rptr;
        bus.b_rvalid   = ~empty;
        bus.b_rinc     = pop_acc;
      end
      ST_BA: begin
        bus.b_push_ack = push_acc;
        bus.b_addr     = wptr;
        bus.a_addr     = rptr;
        bus.a_rvalid   = ~empty;
        bus.a_rinc     = pop_acc;
      end
      default: ;
    endcase
  end

  assign dir = dir_q;
endmodule

// File: doc/fifo_dir_ctrl.md
# fifo_dir_ctrl

Single-clock direction controller and pointer sequencer for the two-port bidirectional FIFO memory `fifomem_dp`, with both memory ports on one clock.
- It owns the write/read pointers, the fill count and the transfer direction (A→B or B→A), and generates every address and strobe for the memory.
- It arbitrates between side A and side B when both want to transmit, and switches direction only when the buffer is empty.
- It sits between two symmetric requester interfaces and the memory; data never passes through it.

## Interface
Parameters:
- `ADDRSIZE`, 4, memory address bits; DEPTH = 1<<ADDRSIZE.
- `BURST_MAX`, 8, pushes the current sender may make before a waiting opposite side wins the next switch; range 1..255.

Ports (x ∈ {a,b}):
- `clk`  in  1  single clock; memory `a_clk` and `b_clk` are tied to it.
- `rst_n`  in  1  synchronous, active-low reset.
- `x_push_req`  in  1  side x has a word to send.
- `x_push_ack`  out  1  push accepted this cycle; drive memory `x_winc` from it.
- `x_rvalid`  out  1  a word for side x is readable on memory `x_rdata`.
- `x_pop`  in  1  side x consumes the word; ignored unless `x_rvalid`.
- `x_addr`  out  ADDRSIZE  memory address for port x.
- `x_rinc`  out  1  equals `x_pop & x_rvalid`.
- `dir`  out  1  0 = A→B, 1 = B→A.
- `count`  out  ADDRSIZE+1  words stored, 0..DEPTH.

## Operation
- States: `AB` (A writes, B reads), `BA` (B writes, A reads), `TURN` (one-cycle turnaround).
- In `AB`:
  - `a_addr` = wptr; `b_addr` = rptr.
  - `a_push_ack = a_push_req & (count != DEPTH)`.
  - `b_rvalid = (count != 0)`.
  - `b_push_ack = a_rvalid = 0`.
- `BA` is the mirror image of `AB`.
- `TURN`: all acks, rvalids and rincs are 0; addresses are 0.
- Pointers wrap modulo DEPTH.
- Count update:
  - push only: +1.
  - pop only: −1.
  - push and pop in the same cycle: unchanged.
- Full (count == DEPTH): push refused, even when a pop occurs in the same cycle.
- Empty: pop not offered. There is no bypass from push to pop in the same cycle.
- `burst` counter:
  - Saturates at BURST_MAX.
  - Increments on each accepted push.
  - Clears on entry to `TURN`.
- Switch condition, from `AB` (mirror for `BA`): count == 0, no push accepted this cycle, `b_push_req` = 1, and either `a_push_req` = 0 or burst == BURST_MAX.
- Switch sequence: →`TURN` for one cycle, then →`BA`. On that transition wptr, rptr and count are set to 0 and `dir` toggles. Memory contents are not retained across a switch.
- `TURN` always completes, regardless of inputs.

## Timing
- Reset values: state `AB`, `dir` = 0, wptr = rptr = count = burst = 0. All acks, rvalids and rincs are 0. Addresses are 0.
- Acks and rvalids are combinational from registered state and the current `x_push_req`. There is no path from `x_pop` to any ack.
- Push-to-pop latency:
  - A word pushed in cycle n has rvalid at the opposite side in n+1, because count is registered.
  - The data is valid on the opposite `x_rdata` in that cycle (fall-through memory).
- Switch latency: the cycle in which the buffer is empty and the switch condition holds is cycle n. The state is `TURN` in n+1, and the first opposite ack can occur in n+2.
- Reset asserted in any state, including `TURN` or a non-empty buffer, returns to the reset values on the next edge.

## Structure
- Package `fifo_dir_pkg` holds:
  - state encoding localparams `ST_AB`, `ST_BA`, `ST_TURN`;
  - `DIR_AB` = 0 and `DIR_BA` = 1;
  - the count-width function (ADDRSIZE+1).
- Sub-module `fifo_dir_ptr`: wptr/rptr/count registers with inc, dec, clear and full/empty flags. It is instantiated once.
- The top level holds the FSM, the burst counter and the port muxing.
- Target: 150–250 lines of RTL.

## Test plan
- Reset and single transfer:
  - After reset, assert `a_push_req` for 1 cycle. Expect `a_push_ack` = 1 with `a_addr` = 0.
  - Next cycle: `b_rvalid` = 1, `b_addr` = 0, count = 1.
  - Pulse `b_pop`. Expect count = 0 and `b_rvalid` = 0.
- Full/wrap with ADDRSIZE = 4:
  - 16 pushes from A give count = 16 and `a_push_ack` = 0 on a 17th request, including when `b_pop` is high in the same cycle.
  - 16 pops return addresses 0..15.
  - The next push uses `a_addr` = 0.
- Simultaneous push and pop at count = 5: `a_addr` and `b_addr` both advance by 1 and count stays 5.
- Switch when empty:
  - Buffer empty, `dir` = 0, `a_push_req` = 0, `b_push_req` = 1.
  - Expect `TURN` for 1 cycle with all acks 0, then `b_push_ack` = 1, `dir` = 1, `b_addr` = 0.
- Fairness with BURST_MAX = 4:
  - Both requests held high. Expect A to get 4 acks, then (once drained to empty) a switch, then B to get 4 acks, and the alternation to repeat.
  - While non-empty, `b_push_req` never causes a switch.
- Reset mid-operation: `rst_n` = 0 during `TURN` with `dir` = 1. After one edge expect `dir` = 0, count = 0 and all outputs at their reset values.
